// File: rtl/psr_cond_unit_pkg.sv
// Shared definitions for the PSR / condition unit: ALU opcodes, PSR bit layout
// and the 4-bit condition-field encoding.
package psr_cond_unit_pkg;

    localparam logic [4:0] OP_CMP  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_ADDC = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_SUBC = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_MOV  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;

    localparam int unsigned PSR_W = 6;
    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;
    localparam int unsigned PSR_E = 5;

    typedef enum logic [3:0] {
        CondEq = 4'd0,  CondNe = 4'd1,  CondCs = 4'd2,  CondCc = 4'd3,
        CondHi = 4'd4,  CondLs = 4'd5,  CondGt = 4'd6,  CondLe = 4'd7,
        CondFs = 4'd8,  CondFc = 4'd9,  CondLo = 4'd10, CondHs = 4'd11,
        CondLt = 4'd12, CondGe = 4'd13, CondUc = 4'd14, CondNv = 4'd15
    } cond_e;

endpackage

// File: rtl/psr_cond_unit_if.sv
// Controller/ALU-side bundle of the PSR unit: flag commit, PSR load/store,
// interrupt save/restore and condition evaluation.
interface psr_cond_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [4:0]       alu_op;
    logic [4:0]       con_codes;
    logic             flag_we;
    logic             psr_load;
    logic [WIDTH-1:0] psr_wdata;
    logic             irq_save;
    logic             irq_restore;
    logic [3:0]       cond;
    logic [WIDTH-1:0] psr;
    logic             carry_out;
    logic             cond_true;
    logic             int_en;

    modport master (
        output alu_op, con_codes, flag_we, psr_load, psr_wdata, irq_save, irq_restore, cond,
        input  psr, carry_out, cond_true, int_en
    );

    modport slave (
        input  alu_op, con_codes, flag_we, psr_load, psr_wdata, irq_save, irq_restore, cond,
        output psr, carry_out, cond_true, int_en
    );
endinterface

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational decoder of the 4-bit condition field over a 6-bit PSR flag vector;
// shared by branch/jump and Scond.
module psr_cond_unit_cond_eval
    import psr_cond_unit_pkg::*;
(
    input  logic [PSR_W-1:0] flags_i,
    input  logic [3:0]       cond_i,
    output logic             true_o
);

    logic c, l, f, z, n;

    assign c = flags_i[PSR_C];
    assign l = flags_i[PSR_L];
    assign f = flags_i[PSR_F];
    assign z = flags_i[PSR_Z];
    assign n = flags_i[PSR_N];

    always_comb begin
        true_o = 1'b0;
        unique case (cond_e'(cond_i))
            CondEq: true_o = z;
            CondNe: true_o = !z;
            CondCs: true_o = c;
            CondCc: true_o = !c;
            CondHi: true_o = l;
            CondLs: true_o = !l;
            CondGt: true_o = n;
            CondLe: true_o = !n;
            CondFs: true_o = f;
            CondFc: true_o = !f;
            CondLo: true_o = !l && !z;
            CondHs: true_o = l || z;
            CondLt: true_o = !n && !z;
            CondGe: true_o = n || z;
            CondUc: true_o = 1'b1;
            CondNv: true_o = 1'b0;
        endcase
    end

    logic unused_flags;
    assign unused_flags = flags_i[PSR_E];

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register: latches ALU flags, handles LPR/SPR and a one-deep
// interrupt shadow, and evaluates branch conditions.
module psr_cond_unit
    import psr_cond_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          BYPASS = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    psr_cond_unit_if.slave  bus
);

    logic [PSR_W-1:0] psr_q, psr_d;
    logic [PSR_W-1:0] shadow_q, shadow_d;
    logic [PSR_W-1:0] flag_src;
    logic [4:0]       flag_mask;

    // con_codes share the PSR bit positions, so a mask selects which flags an op owns.
    always_comb begin
        flag_mask = 5'b0;
        if (bus.flag_we) begin
            unique case (bus.alu_op)
                OP_CMP:                         flag_mask = 5'b11010;
                OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: flag_mask = 5'b00101;
                default:                        flag_mask = 5'b0;
            endcase
        end
    end

    always_comb begin
        psr_d    = psr_q;
        shadow_d = shadow_q;
        if (bus.irq_restore) begin
            psr_d = shadow_q;
        end else begin
            if (bus.psr_load) begin
                psr_d = bus.psr_wdata[PSR_W-1:0];
            end else begin
                psr_d[4:0] = (psr_q[4:0] & ~flag_mask) | (bus.con_codes & flag_mask);
            end
            if (bus.irq_save) begin
                shadow_d     = psr_q;
                psr_d[PSR_E] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q    <= '0;
            shadow_q <= '0;
        end else begin
            psr_q    <= psr_d;
            shadow_q <= shadow_d;
        end
    end

    // While in reset the pending write is meaningless, so fall back to the cleared PSR.
    assign flag_src = (BYPASS && rst_n) ? psr_d : psr_q;

    psr_cond_unit_cond_eval u_cond_eval (
        .flags_i (flag_src),
        .cond_i  (bus.cond),
        .true_o  (bus.cond_true)
    );

    assign bus.psr       = WIDTH'(psr_q);
    assign bus.carry_out = psr_q[PSR_C];
    assign bus.int_en    = psr_q[PSR_E];

    logic unused_wdata;
    assign unused_wdata = ^bus.psr_wdata[WIDTH-1:PSR_W];

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: BYPASS=1 and BYPASS=0 instances share stimulus.
module tb_psr_cond_unit;

    localparam int S_PSR = 0, S_CARRY = 1, S_CT = 2, S_INTEN = 3, S_CT0 = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psr_cond_unit_if #(.WIDTH(16)) bus ();
    psr_cond_unit_if #(.WIDTH(16)) bus0 ();

    assign bus0.alu_op      = bus.alu_op;
    assign bus0.con_codes   = bus.con_codes;
    assign bus0.flag_we     = bus.flag_we;
    assign bus0.psr_load    = bus.psr_load;
    assign bus0.psr_wdata   = bus.psr_wdata;
    assign bus0.irq_save    = bus.irq_save;
    assign bus0.irq_restore = bus.irq_restore;
    assign bus0.cond        = bus.cond;

    psr_cond_unit #(.WIDTH(16), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    psr_cond_unit #(.WIDTH(16), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            S_PSR:   return bus.psr;
            S_CARRY: return {15'b0, bus.carry_out};
            S_CT:    return {15'b0, bus.cond_true};
            S_INTEN: return {15'b0, bus.int_en};
            default: return {15'b0, bus0.cond_true};
        endcase
    endfunction

    // Monitor: at every falling edge, retire all entries due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    n_cmp++;
                    if (actual(sb[i].sel) !== sb[i].val) begin
                        n_bad++;
                        $display("FAIL %s: got %h, want %h (cycle %0d)", sb[i].name,
                                 actual(sb[i].sel), sb[i].val, cyc);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: never checked, want %h", sb[i].name, sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    logic [15:0] sweep_tbl;

    initial begin
        rst_n = 1'b0;
        bus.alu_op = '0; bus.con_codes = '0; bus.flag_we = 1'b0; bus.psr_load = 1'b0;
        bus.psr_wdata = '0; bus.irq_save = 1'b0; bus.irq_restore = 1'b0; bus.cond = 4'd0;
        sweep_tbl = 16'h6566;
        step(); step(); rst_n = 1'b1;
        step();
        expect_at(0, S_PSR, 16'h0000, "reset_psr");
        expect_at(0, S_INTEN, 16'h0, "reset_int_en");
        // Fill PSR, then reset asynchronously in the middle of a cycle
        step(); bus.psr_load = 1'b1; bus.psr_wdata = 16'h003F;
        expect_at(1, S_PSR, 16'h003F, "load_3f");
        expect_at(1, S_CARRY, 16'h1, "load_3f_carry");
        expect_at(1, S_INTEN, 16'h1, "load_3f_int_en");
        step(); bus.psr_load = 1'b0;
        step(); bus.cond = 4'd14; #2 rst_n = 1'b0;
        expect_at(0, S_PSR, 16'h0000, "async_rst_psr");
        expect_at(0, S_CARRY, 16'h0, "async_rst_carry");
        expect_at(0, S_CT, 16'h1, "rst_cond_uc");
        step(); bus.cond = 4'd15;
        expect_at(0, S_CT, 16'h0, "rst_cond_never");
        expect_at(0, S_CT0, 16'h0, "rst_cond_never_nobyp");
        step(); rst_n = 1'b1; bus.cond = 4'd0;
        // CMP update with same-cycle branch
        step(); bus.alu_op = 5'd0; bus.con_codes = 5'b11111; bus.flag_we = 1'b1;
        expect_at(0, S_CT, 16'h1, "cmp_bypass_eq");
        expect_at(0, S_CT0, 16'h0, "cmp_nobypass_eq");
        expect_at(1, S_PSR, 16'h001A, "cmp_psr");
        step(); bus.flag_we = 1'b0;
        expect_at(0, S_CT0, 16'h1, "nobypass_eq_late");
        step(); bus.cond = 4'd2;
        expect_at(0, S_CT, 16'h0, "cmp_cs");
        // ADD update; carry_out must not bypass
        step(); bus.alu_op = 5'd3; bus.con_codes = 5'b00101; bus.flag_we = 1'b1;
        expect_at(0, S_CT, 16'h1, "add_bypass_cs");
        expect_at(0, S_CT0, 16'h0, "add_nobypass_cs");
        expect_at(0, S_CARRY, 16'h0, "carry_no_bypass");
        expect_at(1, S_PSR, 16'h001F, "add_psr");
        expect_at(1, S_CARRY, 16'h1, "add_carry");
        step(); bus.alu_op = 5'd7; bus.con_codes = 5'b00000;
        expect_at(1, S_PSR, 16'h001F, "xor_no_update");
        // Priority: load over flags, restore over load
        step(); bus.alu_op = 5'd0; bus.con_codes = 5'b11111;
        bus.psr_load = 1'b1; bus.psr_wdata = 16'h0021;
        expect_at(1, S_PSR, 16'h0021, "load_beats_cmp");
        step(); bus.flag_we = 1'b0; bus.psr_wdata = 16'h0005;
        step(); bus.psr_load = 1'b0; bus.irq_save = 1'b1;
        expect_at(0, S_PSR, 16'h0005, "load_05");
        step(); bus.irq_save = 1'b0; bus.psr_load = 1'b1; bus.psr_wdata = 16'h003F;
        bus.irq_restore = 1'b1;
        expect_at(1, S_PSR, 16'h0005, "restore_beats_load");
        // Interrupt save/restore
        step(); bus.irq_restore = 1'b0; bus.psr_wdata = 16'h0023;
        step(); bus.psr_load = 1'b0; bus.irq_save = 1'b1;
        expect_at(0, S_INTEN, 16'h1, "pre_irq_int_en");
        expect_at(1, S_PSR, 16'h0003, "irq_save_psr");
        expect_at(1, S_INTEN, 16'h0, "irq_save_int_en");
        step(); bus.irq_save = 1'b0;
        step(); bus.irq_restore = 1'b1;
        expect_at(1, S_PSR, 16'h0023, "irq_restore_psr");
        expect_at(1, S_INTEN, 16'h1, "irq_restore_int_en");
        // Save combined with a flag update, then save+restore leaves shadow alone
        step(); bus.irq_restore = 1'b0; bus.irq_save = 1'b1;
        bus.alu_op = 5'd3; bus.con_codes = 5'b00000; bus.flag_we = 1'b1;
        expect_at(1, S_PSR, 16'h0002, "save_with_flags");
        step(); bus.flag_we = 1'b0; bus.irq_restore = 1'b1;
        expect_at(1, S_PSR, 16'h0023, "save_restore_combo");
        step(); bus.irq_save = 1'b0; bus.irq_restore = 1'b0;
        bus.psr_load = 1'b1; bus.psr_wdata = 16'h0000;
        step(); bus.psr_load = 1'b0; bus.irq_restore = 1'b1;
        expect_at(1, S_PSR, 16'h0023, "shadow_kept");
        // Compound conditions
        step(); bus.irq_restore = 1'b0; bus.psr_load = 1'b1; bus.psr_wdata = 16'h0000;
        step(); bus.psr_load = 1'b0; bus.cond = 4'd12;
        expect_at(0, S_CT, 16'h1, "lt_true");
        step(); bus.cond = 4'd13;
        expect_at(0, S_CT, 16'h0, "ge_false");
        step(); bus.psr_load = 1'b1; bus.psr_wdata = 16'h0008;
        step(); bus.psr_load = 1'b0; bus.cond = 4'd10;
        expect_at(0, S_CT, 16'h0, "lo_false");
        step(); bus.cond = 4'd11;
        expect_at(0, S_CT, 16'h1, "hs_true");
        // Full decode sweep over PSR = N,F,C set
        step(); bus.psr_load = 1'b1; bus.psr_wdata = 16'hFF15;
        step(); bus.psr_load = 1'b0;
        expect_at(0, S_PSR, 16'h0015, "upper_bits_zero");
        for (int c = 0; c < 16; c++) begin
            bus.cond = 4'(c);
            expect_at(0, S_CT, {15'b0, sweep_tbl[c]}, $sformatf("sweep_cond%0d", c));
            expect_at(0, S_CT0, {15'b0, sweep_tbl[c]}, $sformatf("sweep_nobyp_cond%0d", c));
            step();
        end
        step(); step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
